fetch_unit: RTL and testbench

Instruction-fetch stage with program counter. It drives the shared fetch address to the BIOS ROM and the instruction memory, and muxes the returned word by boot mode. The selected word and its PC are registered into the IF/ID pipeline register. It sequences boot: BIOS runs until its halt, then control hands off to the instruction memory at address 0, and a halt in user code parks the core.

---
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC, BIOS/IM boot sequencing and IF/ID register
// BIOS runs until its halt word, then fetch hands off to instruction memory at address 0.
module fetch_unit #(
   parameter int               PC_WIDTH    = 26,
   parameter int               BIOS_SIZE   = 22,
   parameter logic [5:0]       HALT_OPCODE = 6'b011000,
   parameter logic [31:0]      NOP_WORD    = 32'h0000_0000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                stall,
   input  logic                branch_taken,
   input  logic [PC_WIDTH-1:0] branch_target,
   input  logic                resume,
   input  logic [31:0]         bios_instr,
   input  logic [31:0]         im_instr,
   output logic [PC_WIDTH-1:0] pc,
   output logic [31:0]         if_instr,
   output logic [PC_WIDTH-1:0] if_pc,
   output logic                if_valid,
   output logic                boot_mode,
   output logic                halted
);

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_RUN,
      ST_HALTED
   } state_e;

   state_e              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [31:0]         if_instr_q, if_instr_d;
   logic [PC_WIDTH-1:0] if_pc_q, if_pc_d;
   logic                if_valid_q, if_valid_d;
   logic                boot_mode_q, boot_mode_d;

   logic [31:0]         fetched;
   logic                is_halt;
   logic                bios_overrun;
   logic [PC_WIDTH-1:0] pc_inc;

   assign fetched      = boot_mode_q ? bios_instr : im_instr;
   assign is_halt      = (fetched[31:26] == HALT_OPCODE);
   assign bios_overrun = (pc_q >= PC_WIDTH'(BIOS_SIZE));
   assign pc_inc       = pc_q + PC_WIDTH'(1);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      if_instr_d  = if_instr_q;
      if_pc_d     = if_pc_q;
      if_valid_d  = if_valid_q;
      boot_mode_d = boot_mode_q;

      case (state_q)
         ST_BOOT, ST_RUN: begin
            if (branch_taken) begin
               pc_d       = branch_target;
               if_valid_d = 1'b0;
            end else if (stall) begin
               // everything holds; no halt detection while stalled
            end else if (state_q == ST_BOOT && bios_overrun) begin
               // fetching past the BIOS image parks the core until reset
               state_d    = ST_HALTED;
               if_valid_d = 1'b0;
            end else if (is_halt && state_q == ST_BOOT) begin
               if_valid_d  = 1'b0;
               pc_d        = '0;
               boot_mode_d = 1'b0;
               state_d     = ST_RUN;
            end else begin
               if_instr_d = fetched;
               if_pc_d    = pc_q;
               if_valid_d = 1'b1;
               pc_d       = pc_inc;
               if (is_halt) begin
                  state_d = ST_HALTED;
               end
            end
         end
         ST_HALTED: begin
            if_valid_d = 1'b0;
            if (resume && !boot_mode_q) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_HALTED;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_BOOT;
         pc_q        <= '0;
         if_instr_q  <= NOP_WORD;
         if_pc_q     <= '0;
         if_valid_q  <= 1'b0;
         boot_mode_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         if_instr_q  <= if_instr_d;
         if_pc_q     <= if_pc_d;
         if_valid_q  <= if_valid_d;
         boot_mode_q <= boot_mode_d;
      end
   end

   assign pc        = pc_q;
   assign if_instr  = if_instr_q;
   assign if_pc     = if_pc_q;
   assign if_valid  = if_valid_q;
   assign boot_mode = boot_mode_q;
   assign halted    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a behavioural model
// Memories are address-derived functions; halt words are planted at chosen addresses.
module tb_fetch_unit;
   localparam int PW = 26;

   logic          clock = 1'b0;
   logic          reset, stall, branch_taken, resume;
   logic [PW-1:0] branch_target;
   logic [31:0]   bios_instr, im_instr;
   logic [PW-1:0] pc, if_pc;
   logic [31:0]   if_instr;
   logic          if_valid, boot_mode, halted;

   logic [PW-1:0] bios_halt, im_halt, bios_seed, im_seed;
   bit            bios_hen, im_hen;
   int            tests = 0;
   int            failed = 0;

   logic [PW-1:0] m_pc, m_ifpc;
   logic [31:0]   m_instr;
   bit            m_valid, m_boot, m_parked;

   always #5 clock = ~clock;

   fetch_unit dut (
      .clock(clock), .reset(reset), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .resume(resume), .bios_instr(bios_instr),
      .im_instr(im_instr), .pc(pc), .if_instr(if_instr), .if_pc(if_pc),
      .if_valid(if_valid), .boot_mode(boot_mode), .halted(halted)
   );

   function automatic logic [31:0] mem_word(input logic [PW-1:0] a, input logic [PW-1:0] ha,
                                            input bit hen, input logic [PW-1:0] seed);
      logic [PW-1:0] lo;
      lo = a ^ seed;
      if (hen && a == ha) return {6'b011000, lo};
      return {4'b0001, a[1:0], lo};
   endfunction

   assign bios_instr = mem_word(pc, bios_halt, bios_hen, bios_seed);
   assign im_instr   = mem_word(pc, im_halt, im_hen, im_seed);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: one edge of the fetch stage expressed as the boot/run/park rules.
   task automatic model(input bit st, input bit br, input logic [PW-1:0] tgt,
                        input bit rs, input bit rst);
      logic [31:0] w;
      w = m_boot ? mem_word(m_pc, bios_halt, bios_hen, bios_seed)
                 : mem_word(m_pc, im_halt, im_hen, im_seed);
      if (rst) begin
         m_pc = 0; m_ifpc = 0; m_instr = 0; m_valid = 0; m_boot = 1; m_parked = 0;
      end else if (m_parked) begin
         m_valid = 0;
         if (rs && !m_boot) m_parked = 0;
      end else if (br) begin
         m_pc = tgt; m_valid = 0;
      end else if (st) begin
      end else if (m_boot && m_pc >= 22) begin
         m_parked = 1; m_valid = 0;
      end else if (m_boot && w[31:26] == 6'b011000) begin
         m_valid = 0; m_pc = 0; m_boot = 0;
      end else begin
         m_instr = w; m_ifpc = m_pc; m_valid = 1; m_pc = m_pc + 1;
         if (w[31:26] == 6'b011000) m_parked = 1;
      end
   endtask

   task automatic step(input bit st, input bit br, input logic [PW-1:0] tgt,
                       input bit rs, input bit rst, input string tag);
      reset = rst; stall = st; branch_taken = br; branch_target = tgt; resume = rs;
      model(st, br, tgt, rs, rst);
      @(posedge clock);
      #1;
      check({tag, ".pc"}, 32'(pc), 32'(m_pc));
      check({tag, ".if_instr"}, if_instr, m_instr);
      check({tag, ".if_pc"}, 32'(if_pc), 32'(m_ifpc));
      check({tag, ".if_valid"}, 32'(if_valid), 32'(m_valid));
      check({tag, ".boot_mode"}, 32'(boot_mode), 32'(m_boot));
      check({tag, ".halted"}, 32'(halted), 32'(m_parked));
   endtask

   initial begin
      bit st, br, rs;
      logic [PW-1:0] tgt;
      reset = 1; stall = 0; branch_taken = 0; branch_target = 0; resume = 0;
      bios_seed = 0; im_seed = 0; bios_hen = 1; bios_halt = 21; im_hen = 0; im_halt = 0;

      step(0, 0, 0, 0, 1, "reset");
      check("reset_pc", 32'(pc), 0);
      check("reset_if_instr", if_instr, 32'h0);
      check("reset_boot_mode", 32'(boot_mode), 1);

      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, "boot_seq");
      check("boot_pc4", 32'(pc), 4);
      check("boot_if_pc3", 32'(if_pc), 3);

      for (int i = 0; i < 200; i++) begin
         if (!m_boot) break;
         st = ($urandom_range(0, 3) == 0);
         step(st, 0, 0, 0, 0, "boot_run");
      end
      check("handoff_pc", 32'(pc), 0);
      check("handoff_boot_mode", 32'(boot_mode), 0);
      check("handoff_if_valid", 32'(if_valid), 0);
      step(0, 0, 0, 0, 0, "im_first");
      check("im0_if_pc", 32'(if_pc), 0);
      check("im0_if_instr", if_instr, mem_word(0, im_halt, im_hen, im_seed));
      check("im0_if_valid", 32'(if_valid), 1);

      for (int i = 0; i < 10; i++) begin
         if (m_pc == 5) break;
         step(0, 0, 0, 0, 0, "run_to5");
      end
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0, 0, "stall");
         check("stall_pc", 32'(pc), 5);
      end
      step(1, 1, 40, 0, 0, "stall_branch");
      check("stall_branch_pc", 32'(pc), 40);
      check("stall_branch_valid", 32'(if_valid), 0);

      im_hen = 1; im_halt = 9;
      step(0, 1, 7, 0, 0, "br7");
      step(0, 0, 0, 0, 0, "f7");
      step(0, 0, 0, 0, 0, "f8");
      step(0, 0, 0, 0, 0, "halt9");
      check("halt_if_pc", 32'(if_pc), 9);
      check("halt_if_instr", 32'(if_instr[31:26]), 32'h18);
      check("halt_halted", 32'(halted), 1);
      check("halt_pc", 32'(pc), 10);
      step(1, 1, 3, 0, 0, "parked");
      check("parked_valid", 32'(if_valid), 0);
      check("parked_pc", 32'(pc), 10);
      step(0, 1, 33, 1, 0, "resume_br");
      check("resume_pc", 32'(pc), 10);
      check("resume_halted", 32'(halted), 0);
      step(0, 0, 0, 0, 0, "after_resume");
      check("after_resume_if_pc", 32'(if_pc), 10);
      check("after_resume_valid", 32'(if_valid), 1);

      im_seed = PW'($urandom);
      for (int i = 0; i < 300; i++) begin
         if (i % 50 == 0) im_halt = PW'($urandom_range(0, 63));
         st  = ($urandom_range(0, 3) == 0);
         br  = ($urandom_range(0, 9) == 0);
         tgt = PW'($urandom_range(0, 63));
         rs  = ($urandom_range(0, 5) == 0);
         step(st, br, tgt, rs, 0, "rand_run");
      end

      im_hen = 0;
      if (m_parked) step(0, 0, 0, 1, 0, "unpark");
      step(0, 1, {PW{1'b1}}, 0, 0, "br_top");
      step(0, 0, 0, 0, 0, "wrap");
      check("wrap_pc", 32'(pc), 0);
      check("wrap_if_pc", 32'(if_pc), 32'h03ff_ffff);
      step(1, 0, 0, 0, 0, "stall_pre_reset");
      step(1, 0, 0, 0, 1, "reset_mid_stall");
      check("rst_stall_pc", 32'(pc), 0);
      check("rst_stall_if_pc", 32'(if_pc), 0);
      check("rst_stall_if_instr", if_instr, 32'h0);
      check("rst_stall_valid", 32'(if_valid), 0);
      check("rst_stall_boot", 32'(boot_mode), 1);
      check("rst_stall_halted", 32'(halted), 0);

      bios_hen = 0;
      step(0, 0, 0, 0, 0, "fault_f0");
      step(0, 1, 22, 0, 0, "fault_br22");
      step(0, 0, 0, 0, 0, "fault");
      check("fault_halted", 32'(halted), 1);
      check("fault_boot", 32'(boot_mode), 1);
      check("fault_pc", 32'(pc), 22);
      check("fault_valid", 32'(if_valid), 0);
      step(0, 0, 0, 1, 0, "fault_resume");
      check("fault_resume_halted", 32'(halted), 1);
      step(0, 0, 0, 0, 1, "fault_reset");
      check("fault_reset_pc", 32'(pc), 0);
      check("fault_reset_boot", 32'(boot_mode), 1);
      check("fault_reset_halted", 32'(halted), 0);

      for (int r = 0; r < 4; r++) begin
         bios_seed = PW'($urandom);
         bios_halt = PW'($urandom_range(0, 21));
         bios_hen  = 1;
         step(0, 0, 0, 0, 1, "rand_boot_rst");
         for (int i = 0; i < 60; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 7) == 0);
            tgt = PW'($urandom_range(0, 24));
            rs  = ($urandom_range(0, 5) == 0);
            step(st, br, tgt, rs, 0, "rand_boot");
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
